// File: rtl/dircc_node_debug_ocimem_seq.sv
// rtl/dircc_node_debug_ocimem_seq.sv - debug single-word memory access sequencer (Avalon-MM master)
// Optional stall abort enabled by DIRCC_DEBUG_OCIMEM_TIMEOUT_EN.
module dircc_node_debug_ocimem_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_PATTERN    = 32'hDEADDEAD
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_no_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   output logic [31:0] MonDReg,
   output logic        monitor_ready,
   output logic        monitor_error,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [29:0] mon_a_q, mon_a_d;   // word address; byte address is {mon_a_q, 2'b00}
   logic [31:0] mon_d_q, mon_d_d;
   logic        err_q, err_d;
   logic        strobe_any;
   logic        strobe_multi;
   logic        abort;
   logic [6:0]  unused_jdo;

   assign strobe_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign strobe_multi = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                       | (take_action_ocimem_b & take_no_action_ocimem_a);
   assign unused_jdo   = {jdo[37], jdo[35:32], jdo[1:0]};

`ifdef DIRCC_DEBUG_OCIMEM_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] to_cnt_q, to_cnt_d;

   // Counter is parked at zero while idle, so it starts clean on entry to READ/WRITE.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == ST_IDLE) begin
         to_cnt_d = 16'd0;
      end else if (avm_waitrequest) begin
         to_cnt_d = to_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q <= 16'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   assign abort = avm_waitrequest && (to_cnt_q == TO_LAST);
`else
   logic [47:0] unused_cfg;

   assign unused_cfg = {16'(TIMEOUT_CYCLES), ERR_PATTERN};
   assign abort      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mon_a_d = mon_a_q;
      mon_d_d = mon_d_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (take_action_ocimem_a) begin
               mon_a_d = jdo[31:2];
               err_d   = strobe_multi;
               if (jdo[36]) begin
                  state_d = ST_READ;
               end
            end else if (take_action_ocimem_b) begin
               mon_d_d = jdo[31:0];
               err_d   = err_q | strobe_multi;
               state_d = ST_WRITE;
            end else if (take_no_action_ocimem_a) begin
               state_d = ST_READ;
            end
         end
         ST_READ, ST_WRITE: begin
            if (strobe_any) begin
               err_d = 1'b1;
            end
            if (!avm_waitrequest) begin
               if (state_q == ST_READ) begin
                  mon_d_d = avm_readdata;
               end
               mon_a_d = mon_a_q + 30'd1;
               state_d = ST_IDLE;
            end else if (abort) begin
               mon_d_d = ERR_PATTERN;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mon_a_q <= 30'd0;
         mon_d_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mon_a_q <= mon_a_d;
         mon_d_q <= mon_d_d;
         err_q   <= err_d;
      end
   end

   // Request strobes decode straight from the state register so reset kills them at once.
   assign avm_read       = (state_q == ST_READ);
   assign avm_write      = (state_q == ST_WRITE);
   assign avm_address    = {mon_a_q, 2'b00};
   assign avm_writedata  = mon_d_q;
   assign avm_byteenable = 4'hF;
   assign MonDReg        = mon_d_q;
   assign monitor_ready  = (state_q == ST_IDLE);
   assign monitor_error  = err_q;

endmodule

// File: tb/tb_dircc_node_debug_ocimem_seq.sv
// tb/tb_dircc_node_debug_ocimem_seq.sv - randomized self-checking bench for dircc_node_debug_ocimem_seq
module tb_dircc_node_debug_ocimem_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = '0;
   logic        a_stb = 1'b0, na_stb = 1'b0, b_stb = 1'b0;
   logic [31:0] MonDReg, avm_address, avm_writedata, avm_readdata = '0;
   logic        monitor_ready, monitor_error, avm_read, avm_write;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: debug address/data registers, sticky error and a sparse memory image.
   logic [31:0] m_addr = '0;
   logic [31:0] m_data = '0;
   logic        m_err  = 1'b0;
   logic [31:0] mem [logic [31:0]];

   dircc_node_debug_ocimem_seq #(.TIMEOUT_CYCLES(8), .ERR_PATTERN(32'hDEADDEAD)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(a_stb), .take_no_action_ocimem_a(na_stb), .take_action_ocimem_b(b_stb),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_state(input string tag);
      check_eq({tag, "_ready"}, 64'(monitor_ready), 64'd1);
      check_eq({tag, "_rd"}, 64'(avm_read), 64'd0);
      check_eq({tag, "_wr"}, 64'(avm_write), 64'd0);
      check_eq({tag, "_addr"}, 64'(avm_address), 64'(m_addr));
      check_eq({tag, "_data"}, 64'(MonDReg), 64'(m_data));
      check_eq({tag, "_err"}, 64'(monitor_error), 64'(m_err));
   endtask

   // kind: 0 load only, 1 load+read, 2 read-next, 3 write.
   // extra: add lower-priority strobes in the accept cycle; collide: strobe during a stall.
   task automatic do_cmd(input int kind, input logic [37:0] j_in, input int waits,
                         input bit extra, input bit collide);
      logic [37:0] j;
      logic [31:0] req_addr, rdata;
      bit rd, wr;
      j = j_in;
      if (kind == 0) j[36] = 1'b0;
      if (kind == 1) j[36] = 1'b1;
      check_eq("pre_ready", 64'(monitor_ready), 64'd1);
      jdo = j;
      case (kind)
         0, 1: begin
            a_stb = 1'b1;
            if (extra) begin b_stb = 1'b1; na_stb = 1'($urandom); end
            m_addr = {j[31:2], 2'b00};
            m_err  = extra;
         end
         2: na_stb = 1'b1;
         default: begin
            b_stb = 1'b1;
            if (extra) na_stb = 1'b1;
            m_data = j[31:0];
            m_err  = m_err | extra;
         end
      endcase
      rd = (kind == 1) || (kind == 2);
      wr = (kind == 3);
      @(negedge clk);
      a_stb = 1'b0; na_stb = 1'b0; b_stb = 1'b0;
      jdo[31:0] = $urandom; jdo[37:32] = 6'($urandom);
      if (!rd && !wr) begin
         check_idle_state("load");
         return;
      end
      req_addr = m_addr;
      rdata = '0;
      if (rd) begin
         if (!mem.exists(req_addr)) mem[req_addr] = $urandom;
         rdata = mem[req_addr];
      end
      for (int c = 0; c <= waits; c++) begin
         check_eq("busy_ready", 64'(monitor_ready), 64'd0);
         check_eq("busy_rd", 64'(avm_read), 64'(rd));
         check_eq("busy_wr", 64'(avm_write), 64'(wr));
         check_eq("busy_addr", 64'(avm_address), 64'(req_addr));
         check_eq("busy_be", 64'(avm_byteenable), 64'hF);
         if (wr) check_eq("busy_wdata", 64'(avm_writedata), 64'(m_data));
         avm_waitrequest = (c < waits);
         avm_readdata    = (c < waits) ? $urandom : rdata;
         if (collide && c == 0 && waits > 0) begin
            na_stb = 1'b1;
            m_err  = 1'b1;
         end
         @(negedge clk);
         na_stb = 1'b0;
         avm_waitrequest = 1'b0;
      end
      if (rd) m_data = rdata;
      else mem[req_addr] = m_data;
      m_addr = req_addr + 32'd4;
      check_idle_state("done");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [37:0] j;
      int cnt;
      int pick;

      #1;
      check_eq("rst_ready", 64'(monitor_ready), 64'd1);
      check_eq("rst_err", 64'(monitor_error), 64'd0);
      check_eq("rst_rd", 64'(avm_read), 64'd0);
      check_eq("rst_wr", 64'(avm_write), 64'd0);
      check_eq("rst_data", 64'(MonDReg), 64'd0);
      check_eq("rst_addr", 64'(avm_address), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      mem[32'h0000_1000] = 32'hCAFEF00D;
      do_cmd(1, 38'h10_0000_1003, 0, 0, 0);
      check_eq("t1_data", 64'(MonDReg), 64'hCAFEF00D);
      check_eq("t1_addr", 64'(avm_address), 64'h1004);

      do_cmd(0, 38'h00_0000_0020, 0, 0, 0);
      do_cmd(3, 38'h00_1234_5678, 3, 0, 0);
      check_eq("t2_mem", 64'(mem[32'h20]), 64'h12345678);
      do_cmd(2, '0, 1, 0, 0);

      do_cmd(2, '0, 3, 0, 1);
      check_eq("coll_err", 64'(monitor_error), 64'd1);
      do_cmd(0, 38'h00_0000_0100, 0, 0, 0);
      check_eq("coll_clr", 64'(monitor_error), 64'd0);

      do_cmd(1, 38'h10_FFFF_FFFC, 2, 0, 0);
      check_eq("wrap_addr", 64'(avm_address), 64'd0);

      do_cmd(0, 38'h00_0000_0040, 0, 0, 0);
      na_stb = 1'b1;
      @(negedge clk);
      na_stb = 1'b0;
      avm_waitrequest = 1'b1;
      cnt = 0;
`ifdef DIRCC_DEBUG_OCIMEM_TIMEOUT_EN
      while (avm_read && cnt < 40) begin cnt++; @(negedge clk); end
      avm_waitrequest = 1'b0;
      check_eq("to_cycles", 64'(cnt), 64'd8);
      m_data = 32'hDEADDEAD;
      m_err  = 1'b1;
      check_idle_state("to");
`else
      while (avm_read && cnt < 20) begin cnt++; @(negedge clk); end
      check_eq("noto_held", 64'(cnt), 64'd20);
      check_eq("noto_rd", 64'(avm_read), 64'd1);
      if (!mem.exists(32'h40)) mem[32'h40] = $urandom;
      avm_readdata = mem[32'h40];
      avm_waitrequest = 1'b0;
      @(negedge clk);
      m_data = mem[32'h40];
      m_addr = 32'h44;
      check_idle_state("noto");
`endif

      jdo = 38'h00_5555_AAAA;
      b_stb = 1'b1;
      @(negedge clk);
      b_stb = 1'b0;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      check_eq("mid_wr", 64'(avm_write), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      m_addr = '0; m_data = '0; m_err = 1'b0;
      check_idle_state("arst");
      @(negedge clk);
      avm_waitrequest = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_state("post_rst");

      for (int i = 0; i < 150; i++) begin
         j[31:0] = $urandom;
         j[37:32] = 6'($urandom);
         pick = $urandom_range(0, 3);
         if (pick == 0) j[31:0] = 32'hFFFF_FFFC;
         else if (pick == 1) j[31:0] = j[31:0] & 32'h0000_003F;
         do_cmd($urandom_range(0, 3), j, $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
